// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill: rectangle / full-screen fill engine and VRAM write-port driver
// for a H_RES x V_RES, DATA_W-bit-per-pixel frame buffer (address = y*H_RES + x).
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   reg_we_i      - register write strobe (one write per cycle it is high)
//   reg_addr_i    - 0=X0 1=Y0 2=W 3=H 4=COLOR 5=CMD (6,7 ignored)
//   reg_data_i    - register write data
//   pix_we_i      - direct CPU pixel write strobe
//   pix_addr_i    - direct pixel address (forwarded unchecked)
//   pix_data_i    - direct pixel data
//   v_we_o        - VRAM write enable (registered)
//   v_addr_o      - VRAM write address (registered, holds when v_we_o=0)
//   v_data_o      - VRAM write data (registered, holds when v_we_o=0)
//   busy_o        - high in SETUP and FILL
//   done_o        - one-cycle pulse when an operation finishes
//
// Strobe semantics: reg_we_i and pix_we_i are single-cycle requests with no
// back-pressure. A pixel strobe is always forwarded the following cycle and
// steals that cycle from the engine; register writes outside IDLE are dropped.
//
// Coordinates are 8 bits wide, which covers the 200x150 frame.

module gpu_rect_fill #(
    parameter int H_RES  = 200,
    parameter int V_RES  = 150,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we_i,
    input  logic [2:0]        reg_addr_i,
    input  logic [7:0]        reg_data_i,
    input  logic              pix_we_i,
    input  logic [ADDR_W-1:0] pix_addr_i,
    input  logic [DATA_W-1:0] pix_data_i,
    output logic              v_we_o,
    output logic [ADDR_W-1:0] v_addr_o,
    output logic [DATA_W-1:0] v_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [8:0]        H_RES9 = 9'(H_RES);
    localparam logic [8:0]        V_RES9 = 9'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    state_t state_q;

    // Programming registers
    logic [7:0] x0_q, y0_q, w_q, h_q, color_q;

    // Operation context latched at CMD time / in SETUP
    logic              op_clear_q;
    logic [DATA_W-1:0] fill_color_q;
    logic [7:0]        xs_q, xe_q, ye_q;

    // Next pixel to be written by the engine; cur_y_q == ye_q means finished
    logic [7:0]        cur_x_q, cur_y_q;
    logic [ADDR_W-1:0] row_base_q;

    // SETUP-time bound computation (9-bit sums so X0+W cannot wrap)
    logic [8:0]        x_sum, y_sum;
    logic [7:0]        rect_xe, rect_ye;
    logic              rect_empty;
    logic [7:0]        setup_xs, setup_ys, setup_xe, setup_ye;
    logic              setup_empty;
    logic [ADDR_W-1:0] setup_base;

    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        rect_xe    = (x_sum > H_RES9) ? H_RES9[7:0] : x_sum[7:0];
        rect_ye    = (y_sum > V_RES9) ? V_RES9[7:0] : y_sum[7:0];
        rect_empty = ({1'b0, x0_q} >= H_RES9) || ({1'b0, y0_q} >= V_RES9) ||
                     (w_q == 8'd0) || (h_q == 8'd0);

        if (op_clear_q) begin
            setup_xs    = 8'd0;
            setup_ys    = 8'd0;
            setup_xe    = H_RES9[7:0];
            setup_ye    = V_RES9[7:0];
            setup_empty = 1'b0;
        end else begin
            setup_xs    = x0_q;
            setup_ys    = y0_q;
            setup_xe    = rect_xe;
            setup_ye    = rect_ye;
            setup_empty = rect_empty;
        end
        // The only multiply; it sits in SETUP, the FILL path is add-only.
        setup_base = {{(ADDR_W-8){1'b0}}, setup_ys} * H_RES_A;
    end

    // The engine's "current pixel" view: in SETUP it comes straight from the
    // computed bounds so the first write can be issued on the SETUP edge.
    logic [7:0]        eng_x, eng_y, eng_xs, eng_xe, eng_ye;
    logic [ADDR_W-1:0] eng_base, eng_addr;
    logic              eng_finished, eng_row_end;

    always_comb begin
        eng_x    = cur_x_q;
        eng_y    = cur_y_q;
        eng_xs   = xs_q;
        eng_xe   = xe_q;
        eng_ye   = ye_q;
        eng_base = row_base_q;
        if (state_q == S_SETUP) begin
            eng_x    = setup_xs;
            eng_y    = setup_ys;
            eng_xs   = setup_xs;
            eng_xe   = setup_xe;
            eng_ye   = setup_ye;
            eng_base = setup_base;
        end
        eng_finished = ((state_q == S_SETUP) && setup_empty) || (eng_y == eng_ye);
        eng_row_end  = (eng_x == (eng_xe - 8'd1));
        eng_addr     = eng_base + {{(ADDR_W-8){1'b0}}, eng_x};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            op_clear_q   <= 1'b0;
            fill_color_q <= '0;
            xs_q         <= '0;
            xe_q         <= '0;
            ye_q         <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            row_base_q   <= '0;
            v_we_o       <= 1'b0;
            v_addr_o     <= '0;
            v_data_o     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            v_we_o <= 1'b0;
            done_o <= 1'b0;

            if (pix_we_i) begin
                v_we_o   <= 1'b1;
                v_addr_o <= pix_addr_i;
                v_data_o <= pix_data_i;
            end

            case (state_q)
                S_IDLE: begin
                    if (reg_we_i) begin
                        case (reg_addr_i)
                            3'd0: x0_q    <= reg_data_i;
                            3'd1: y0_q    <= reg_data_i;
                            3'd2: w_q     <= reg_data_i;
                            3'd3: h_q     <= reg_data_i;
                            3'd4: color_q <= reg_data_i;
                            3'd5: begin
                                if (reg_data_i[1] || reg_data_i[0]) begin
                                    op_clear_q   <= reg_data_i[1];
                                    fill_color_q <= DATA_W'(color_q);
                                    busy_o       <= 1'b1;
                                    state_q      <= S_SETUP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_SETUP, S_FILL: begin
                    // A pass-through write owns the port this cycle: the
                    // engine holds every pointer and simply retries.
                    if (!pix_we_i) begin
                        if (eng_finished) begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            v_we_o   <= 1'b1;
                            v_addr_o <= eng_addr;
                            v_data_o <= fill_color_q;
                            xs_q     <= eng_xs;
                            xe_q     <= eng_xe;
                            ye_q     <= eng_ye;
                            if (eng_row_end) begin
                                cur_x_q    <= eng_xs;
                                cur_y_q    <= eng_y + 8'd1;
                                row_base_q <= eng_base + H_RES_A;
                            end else begin
                                cur_x_q    <= eng_x + 8'd1;
                                cur_y_q    <= eng_y;
                                row_base_q <= eng_base;
                            end
                            state_q <= S_FILL;
                        end
                    end
                end

                S_DONE: state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Testbench for gpu_rect_fill: directed boundary cases plus randomized
// operations with random pass-through stalls and ignored busy-time register
// writes, checked cycle by cycle against a pixel-list reference model.

module tb_gpu_rect_fill;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we_i;
    logic [2:0]  reg_addr_i;
    logic [7:0]  reg_data_i;
    logic        pix_we_i;
    logic [14:0] pix_addr_i;
    logic [7:0]  pix_data_i;
    logic        v_we_o;
    logic [14:0] v_addr_o;
    logic [7:0]  v_data_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    gpu_rect_fill dut (
        .clk        (clk),
        .rst        (rst),
        .reg_we_i   (reg_we_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .pix_we_i   (pix_we_i),
        .pix_addr_i (pix_addr_i),
        .pix_data_i (pix_data_i),
        .v_we_o     (v_we_o),
        .v_addr_o   (v_addr_o),
        .v_data_o   (v_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [22:0] exp_q[$];        // {addr, data} of engine pixels, in order
    logic [7:0]  m_x0, m_y0, m_w, m_h, m_color;
    logic [14:0] m_last_addr;
    logic [7:0]  m_last_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {we, busy, done, addr, data}
    function automatic logic [31:0] pack(input logic we, input logic busy, input logic done,
                                         input logic [14:0] a, input logic [7:0] d);
        return {6'b0, we, busy, done, a, d};
    endfunction

    function automatic logic [31:0] observed();
        return pack(v_we_o, busy_o, done_o, v_addr_o, v_data_o);
    endfunction

    // ---------------- reference model ----------------
    task automatic build_expected(input logic [7:0] cmd);
        int xs, ys, xe, ye;
        exp_q.delete();
        xs = 0; ys = 0; xe = 0; ye = 0;
        if (cmd[1]) begin
            xe = 200; ye = 150;
        end else if (cmd[0]) begin
            if (m_x0 < 200 && m_y0 < 150 && m_w != 0 && m_h != 0) begin
                xs = m_x0; ys = m_y0;
                xe = (m_x0 + m_w > 200) ? 200 : m_x0 + m_w;
                ye = (m_y0 + m_h > 150) ? 150 : m_y0 + m_h;
            end
        end
        for (int y = ys; y < ye; y++)
            for (int x = xs; x < xe; x++)
                exp_q.push_back({15'(y * 200 + x), m_color});
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        @(posedge clk); #1;
        reg_we_i = 1'b0;
        case (a)
            3'd0: m_x0 = d;
            3'd1: m_y0 = d;
            3'd2: m_w = d;
            3'd3: m_h = d;
            3'd4: m_color = d;
            default: ;
        endcase
    endtask

    task automatic set_rect(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                            input logic [7:0] h, input logic [7:0] c);
        write_reg(3'd0, x0);
        write_reg(3'd1, y0);
        write_reg(3'd2, w);
        write_reg(3'd3, h);
        write_reg(3'd4, c);
    endtask

    // Issue CMD, then check every cycle from E+1 through the done pulse.
    // stall_at forces a 0x1234/0x55 pass-through on that cycle index.
    task automatic run_op(input logic [7:0] cmd, input int stall_pct, input int stall_at,
                          input int busy_wr_pct, input string tag);
        logic [31:0] cur_exp, nxt;
        logic        cur_done, nxt_done, pix;
        logic [22:0] e;
        int          iter;
        build_expected(cmd);
        @(posedge clk); #1;
        reg_we_i = 1'b1; reg_addr_i = 3'd5; reg_data_i = cmd;
        @(posedge clk); #1;
        reg_we_i = 1'b0;
        if (cmd[1:0] == 2'b00) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_val({tag, "_noop"}, observed(), pack(1'b0, 1'b0, 1'b0, m_last_addr, m_last_data));
            end
            return;
        end
        cur_exp  = pack(1'b0, 1'b1, 1'b0, m_last_addr, m_last_data);
        cur_done = 1'b0;
        iter     = 0;
        forever begin
            pix      = 1'b0;
            nxt      = '0;
            nxt_done = 1'b0;
            if (iter > 0 && !cur_done &&
                (iter == stall_at || $urandom_range(0, 99) < stall_pct)) begin
                pix        = 1'b1;
                pix_we_i   = 1'b1;
                pix_addr_i = (iter == stall_at) ? 15'h1234 : 15'($urandom_range(0, 32767));
                pix_data_i = (iter == stall_at) ? 8'h55 : 8'($urandom_range(0, 255));
            end
            if (iter > 0 && !cur_done && $urandom_range(0, 99) < busy_wr_pct) begin
                reg_we_i   = 1'b1;
                reg_addr_i = 3'($urandom_range(0, 5));
                reg_data_i = 8'($urandom_range(0, 255));
            end
            if (!cur_done) begin
                if (pix) begin
                    m_last_addr = pix_addr_i; m_last_data = pix_data_i;
                    nxt = pack(1'b1, 1'b1, 1'b0, m_last_addr, m_last_data);
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    m_last_addr = e[22:8]; m_last_data = e[7:0];
                    nxt = pack(1'b1, 1'b1, 1'b0, m_last_addr, m_last_data);
                end else begin
                    nxt      = pack(1'b0, 1'b0, 1'b1, m_last_addr, m_last_data);
                    nxt_done = 1'b1;
                end
            end
            @(negedge clk);
            check_val(tag, observed(), cur_exp);
            if (cur_done) break;
            @(posedge clk); #1;
            pix_we_i = 1'b0;
            reg_we_i = 1'b0;
            cur_exp  = nxt;
            cur_done = nxt_done;
            iter++;
            if (iter > 40000) begin
                checks++; failures++;
                $display("FAIL %s_timeout got=%0d cycles exp=done pulse", tag, iter);
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        reg_we_i = 1'b0; reg_addr_i = '0; reg_data_i = '0;
        pix_we_i = 1'b0; pix_addr_i = '0; pix_data_i = '0;
        m_x0 = '0; m_y0 = '0; m_w = '0; m_h = '0; m_color = '0;
        m_last_addr = '0; m_last_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("reset_state", observed(), pack(1'b0, 1'b0, 1'b0, 15'd0, 8'd0));

        // Basic rectangle
        set_rect(8'd10, 8'd5, 8'd3, 8'd2, 8'hE0);
        run_op(8'd1, 0, -1, 0, "rect_basic");

        // Clipping at the bottom-right corner
        set_rect(8'd198, 8'd148, 8'd5, 8'd5, 8'hE0);
        run_op(8'd1, 0, -1, 0, "rect_clip");

        // Empty operations
        write_reg(3'd2, 8'd0);
        run_op(8'd1, 0, -1, 0, "empty_w0");
        set_rect(8'd200, 8'd0, 8'd4, 8'd4, 8'h11);
        run_op(8'd1, 0, -1, 0, "empty_x200");
        run_op(8'd0, 0, -1, 0, "cmd_zero");

        // Full clear with ignored register writes during it, then readback rect
        set_rect(8'd10, 8'd5, 8'd3, 8'd2, 8'h03);
        run_op(8'd2, 0, -1, 1, "clear");
        run_op(8'd3, 0, -1, 0, "rect_after_clear_both_bits_is_clear_no");
        run_op(8'd1, 0, -1, 0, "readback_rect");

        // Pass-through stall in the middle of a 6-pixel fill
        write_reg(3'd4, 8'hE0);
        run_op(8'd1, 0, 3, 0, "stall");

        // Reset during the third write cycle
        @(posedge clk); #1;
        reg_we_i = 1'b1; reg_addr_i = 3'd5; reg_data_i = 8'd1;
        @(posedge clk); #1;             // cycle E+1
        reg_we_i = 1'b0;
        repeat (3) @(posedge clk);      // now in cycle E+4 (third write)
        @(negedge clk);
        check_val("third_write", observed(), pack(1'b1, 1'b1, 1'b0, 15'd1012, 8'hE0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_reset", observed(), pack(1'b0, 1'b0, 1'b0, 15'd0, 8'd0));
        m_x0 = '0; m_y0 = '0; m_w = '0; m_h = '0; m_color = '0;
        m_last_addr = '0; m_last_data = '0;
        run_op(8'd1, 0, -1, 0, "post_reset_empty");

        // Randomized operations
        for (int n = 0; n < 16; n++) begin
            set_rect(8'($urandom_range(0, 205)), 8'($urandom_range(0, 155)),
                     8'($urandom_range(0, 20)), 8'($urandom_range(0, 12)),
                     8'($urandom_range(0, 255)));
            run_op(8'($urandom_range(0, 3)), 20, -1, 10, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_rect_fill.md
Name: gpu_rect_fill

Overview:
- Hardware fill engine and VRAM write-port driver for the 200x150, 8-bit-per-pixel frame buffer.
- The CPU programs a rectangle (or a full-screen clear) through a small register file. The block then streams writes at one pixel per clock into the VRAM write port: we/addr/data, with address = y*200 + x.
- Direct CPU single-pixel writes pass through the same port and take priority over the engine.
- The block sits between the CPU MMIO decode and the GPU's v_we_i/v_addr_i/v_data_i inputs.

Parameters:
- H_RES, 200, display width in pixels.
- V_RES, 150, display height in pixels.
- ADDR_W, 15, VRAM address width.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  3  register select: 0=X0, 1=Y0, 2=W, 3=H, 4=COLOR, 5=CMD.
- reg_data_i  in  8  register write data.
- pix_we_i  in  1  direct CPU pixel write.
- pix_addr_i  in  ADDR_W  direct pixel address.
- pix_data_i  in  DATA_W  direct pixel data.
- v_we_o  out  1  VRAM write enable.
- v_addr_o  out  ADDR_W  VRAM write address.
- v_data_o  out  DATA_W  VRAM write data.
- busy_o  out  1  engine active.
- done_o  out  1  one-cycle pulse when an operation finishes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all registers 0, state IDLE, v_we_o=0, v_addr_o=0, v_data_o=0, busy_o=0, done_o=0.
- Reset mid-operation: the operation is aborted. v_we_o=0 from the cycle after the reset edge; no done pulse is generated.
- Registers:
  - X0, Y0, W, H, COLOR are 8-bit.
  - Writes are accepted only in IDLE; writes while busy are ignored.
  - Writing CMD in IDLE starts an operation. bit0 = rect fill, bit1 = clear screen; bit1 wins if both are set. CMD=0 does nothing.
  - CMD writes while busy are ignored.
- State machine: IDLE -> SETUP -> FILL -> DONE -> IDLE.
  - SETUP (1 cycle) computes the clipped bounds:
    - rect: xs=X0, ys=Y0, xe=min(X0+W, H_RES), ye=min(Y0+H, V_RES), using 9-bit sums.
    - clear: xs=0, ys=0, xe=H_RES, ye=V_RES.
    - row_base=ys*H_RES, cur_x=xs, cur_y=ys.
  - Empty operation: if X0>=H_RES, Y0>=V_RES, W=0 or H=0, SETUP goes directly to DONE and no writes are issued.
  - FILL writes one pixel per cycle: addr = row_base + cur_x, data = COLOR latched at CMD time.
    - cur_x increments each write.
    - At cur_x = xe-1: cur_x <= xs, cur_y++, row_base += H_RES.
    - The last write is (xe-1, ye-1), followed by DONE.
  - DONE lasts 1 cycle: done_o=1, busy_o=0.
- Address arithmetic: row_base is ADDR_W bits and is built incrementally, with no multiplier in the FILL path. The maximum address is 29999, which never wraps.
- busy_o is 1 in SETUP and FILL and 0 otherwise.
- Timing:
  - CMD write sampled at edge E.
  - SETUP in cycle E+1.
  - First v_we_o=1 in cycle E+2.
  - An N-pixel fill holds v_we_o high for N cycles when uncontended. done_o pulses in the cycle after the last write.
  - Empty operation: done_o pulses in cycle E+2.
- Outputs: v_we_o, v_addr_o and v_data_o are registered. When v_we_o=0, v_addr_o and v_data_o hold their previous values.
- Pass-through writes:
  - pix_we_i sampled at edge E produces v_we_o=1, v_addr_o=pix_addr_i, v_data_o=pix_data_i in cycle E+1.
  - This applies in every state.
  - A pass-through write in FILL stalls the engine for that cycle, and cur_x/cur_y/row_base hold. No pixel is skipped or duplicated; done timing shifts by the number of stalls.
- Pass-through addresses are not range-checked; they are forwarded unmodified.

Test Plan:
- X0=10, Y0=5, W=3, H=2, COLOR=0xE0, CMD=1 -> v_we_o for 6 consecutive cycles starting E+2, addrs 1010,1011,1012,1210,1211,1212, data 0xE0. done_o pulses once, immediately after the last write; busy_o falls with it.
- X0=198, Y0=148, W=5, H=5, CMD=1 -> exactly 4 writes, addrs 29798,29799,29998,29999. No address >=30000 is issued.
- W=0, CMD=1 -> no v_we_o. done_o in cycle E+2. Also X0=200, W=4, H=4 -> same result.
- COLOR=0x03, CMD=2 -> 30000 contiguous writes, addr 0..29999, data 0x03, then done_o. Register writes to X0 during the fill are ignored; readback via a following rect shows the old value.
- During a 6-pixel fill, pix_we_i pulsed for 1 cycle with addr 0x1234, data 0x55 -> that cycle v_addr_o=0x1234, v_data_o=0x55. The engine then resumes and all 6 fill addresses still appear, in order, with done_o one cycle later than in the uncontended case.
- rst asserted on the 3rd write cycle of a fill -> v_we_o=0, busy_o=0, done_o=0 the next cycle. A subsequent CMD=1 with no register writes (W=H=0) -> no writes, done_o pulses.
